alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
Parametrised, registered successor to the single-cycle datapath ALU. It keeps the existing 4-bit S_ALU operation encoding and the {S,Z,C,V} flag format. It adds iterative unsigned multiply, divide and remainder under a START/BUSY/DONE handshake. It sits between the register-file read stage and write-back; the controller stalls on BUSY and captures the result on DONE.

Parameters:
WIDTH, 16, datapath width in bits; power of two, minimum 4.
SHW, log2(WIDTH), shift-amount width; derived, not overridden.

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous reset, active-high
START  input  1  operation request; sampled only while BUSY=0
S_ALU  input  4  operation select
DATA_A  input  WIDTH  operand A; signed for SRA and V, unsigned otherwise
DATA_B  input  WIDTH  operand B; low SHW bits are the shift amount
BUSY  output  1  multi-cycle operation in progress
DONE  output  1  one-cycle pulse; ALU_OUT/FLAG_OUT updated this cycle
ALU_OUT  output  WIDTH  registered result
FLAG_OUT  output  4  registered {S, Z, C, V}

Behaviour:
- Reset (async, RST=1): state IDLE; BUSY=0, DONE=0, ALU_OUT=0, FLAG_OUT=0; iteration counter and operand latches cleared.
- Reset mid-operation aborts the operation; no DONE is produced.
- Encoding:
  - ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100
  - MUL 0101, DIVU 0110, REMU 0111
  - SLL 1000, ROL 1001, SRL 1010, SRA 1011
  - IDT 1100 (pass B), NON 1111 (result 0)
  - All other codes behave as NON.
- Single-cycle ops (everything except MUL/DIVU/REMU):
  - START at edge n -> ALU_OUT, FLAG_OUT and DONE=1 at edge n+1.
  - BUSY stays 0.
- Multi-cycle ops:
  - Operands and op are latched at accept.
  - BUSY=1 from edge n+1 through edge n+WIDTH.
  - At edge n+WIDTH+1: BUSY=0, DONE=1, result registered.
  - Latency is WIDTH+1 cycles.
- Handshake:
  - START while BUSY=1 is ignored; no queueing.
  - START in a DONE cycle is accepted, so back-to-back ops are allowed.
  - DONE is high for exactly one cycle per accepted op.
  - ALU_OUT/FLAG_OUT hold their values between DONEs.
- States and transitions:
  - IDLE -> (START & multi-cycle op & B!=0 for DIVU/REMU) -> ITER.
  - ITER -> counter reaches WIDTH-1 -> FINISH.
  - FINISH -> IDLE. FINISH also accepts a new START.
  - Single-cycle ops stay in IDLE.
- MUL: shift-add over WIDTH iterations into a 2*WIDTH product.
  - ALU_OUT = low WIDTH bits.
  - C=1 if the high WIDTH bits are nonzero; V=0.
- DIVU/REMU: restoring division, one quotient bit per iteration.
  - DIVU returns the quotient; REMU returns the remainder.
  - C=0, V=0.
- Divide by zero (B=0 at accept) completes as a single-cycle op:
  - DIVU result = all ones; REMU result = A.
  - V=1, C=0.
- Flags:
  - S = ALU_OUT[WIDTH-1]; Z = (ALU_OUT==0).
  - ADD: C = carry out; V = signed overflow (A,B same sign, result sign differs).
  - SUB: C = borrow (A<B unsigned); V = signed overflow (A,B signs differ, result sign differs from A).
  - Logic/IDT/NON: C=0, V=0.
- Shifts (sh = B[SHW-1:0]):
  - SLL: C = A[WIDTH-sh].
  - ROL: rotate left by sh; C = A[WIDTH-sh].
  - SRL: logical right; C = A[sh-1].
  - SRA: arithmetic right; C = A[sh-1].
  - sh=0: result = A, C=0. V=0 for all shifts.

Test Plan:
- WIDTH=16; reset asserted mid-MUL (cycle 5) -> BUSY=0, DONE never pulses, ALU_OUT=0x0000, FLAG_OUT=0000 immediately (async).
- ADD 0x7FFF+0x0001 -> DONE next cycle, ALU_OUT=0x8000, FLAG_OUT=1001. Then SUB 0x0000-0x0001 -> ALU_OUT=0xFFFF, FLAG_OUT=1010.
- MUL 0x0123*0x0100 -> BUSY 16 cycles, DONE at cycle 17, ALU_OUT=0x2300, C=1. MUL 0x00FF*0x00FF -> 0xFE01, C=0.
- DIVU 1000/7 -> ALU_OUT=0x008E after 17 cycles. REMU 1000/7 -> 0x0006. DIVU 0x1234/0 -> DONE next cycle, 0xFFFF, V=1.
- START pulsed during BUSY with ADD -> ignored, only one DONE. START in the DONE cycle -> accepted, second DONE at the correct latency.
- SRA 0x8001 by 1 -> 0xC000, C=1. ROL 0x8001 by 4 -> 0x0018, C=0. SLL 0x8000 by 1 -> 0x0000, Z=1, C=1.

Source files
------------

// File: rtl/alu_multicycle.sv
// -----------------------------------------------------------------------------
// alu_multicycle
//   Registered ALU placed between register-file read and write-back. Keeps the
//   4-bit S_ALU operation encoding and the {S,Z,C,V} flag format of the older
//   single-cycle datapath ALU. Adds iterative unsigned multiply, divide and
//   remainder behind a START/BUSY/DONE handshake. Single-cycle operations
//   complete one clock after START. Multi-cycle operations hold BUSY for WIDTH
//   cycles and pulse DONE on the following cycle.
//
// Ports
//   CLK       rising-edge clock
//   RST       asynchronous reset, active high
//   START     operation request, sampled only while BUSY=0
//   S_ALU     operation select
//   DATA_A    operand A (signed for SRA and V, unsigned otherwise)
//   DATA_B    operand B (low SHW bits are the shift amount)
//   BUSY      multi-cycle operation in progress
//   DONE      one-cycle pulse, ALU_OUT/FLAG_OUT updated this cycle
//   ALU_OUT   registered result
//   FLAG_OUT  registered {S, Z, C, V}
//
// state  | meaning
// IDLE   | waiting for START; single-cycle ops complete from here
// ITER   | one multiply/divide step per clock, BUSY=1
// FINISH | result of the iterative op is on ALU_OUT (DONE=1); accepts START
// -----------------------------------------------------------------------------
module alu_multicycle #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [3:0]       S_ALU,
    input  logic [WIDTH-1:0] DATA_A,
    input  logic [WIDTH-1:0] DATA_B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic [3:0]       FLAG_OUT
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_MUL  = 4'b0101;
    localparam logic [3:0] OP_DIVU = 4'b0110;
    localparam logic [3:0] OP_REMU = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_ROL  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_IDT  = 4'b1100;
    localparam logic [3:0] OP_NON  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ITER   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t state, next_state;

    // latched operation and iterative working registers
    // MUL : hi_q = running upper product, lo_q = multiplier shifting out
    // DIV : hi_q = partial remainder,     lo_q = dividend in / quotient out
    logic [3:0]       op_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [SHW-1:0]   cnt_q;

    logic             done_q;
    logic [WIDTH-1:0] out_q;
    logic [3:0]       flag_q;

    // handshake / control
    logic is_multi_op;
    logic div_zero;
    logic accept;
    logic accept_multi;
    logic load_ops;
    logic step_en;
    logic load_single;
    logic load_multi;

    // iteration step
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH-1:0] mc_res;
    logic             mc_c;

    // single-cycle datapath
    logic [SHW-1:0]     sh;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_diff;
    logic [2*WIDTH-1:0] shl_ext;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_c;
    logic               sc_v;

    function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] r,
                                              input logic c,
                                              input logic v);
        return {r[WIDTH-1], (r == '0), c, v};
    endfunction

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // request decode: divide by zero never enters ITER
    always_comb begin
        is_multi_op = (S_ALU == OP_MUL) || (S_ALU == OP_DIVU) || (S_ALU == OP_REMU);
        div_zero    = ((S_ALU == OP_DIVU) || (S_ALU == OP_REMU)) && (DATA_B == '0);
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (START && is_multi_op && !div_zero) next_state = ITER;
            ITER:    if (cnt_q == CNT_LAST) next_state = FINISH;
            FINISH:  next_state = (START && is_multi_op && !div_zero) ? ITER : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs / datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        BUSY         = 1'b0;
        accept       = 1'b0;
        accept_multi = 1'b0;
        load_ops     = 1'b0;
        step_en      = 1'b0;
        load_single  = 1'b0;
        load_multi   = 1'b0;
        case (state)
            IDLE, FINISH: begin
                accept       = START;
                accept_multi = START && is_multi_op && !div_zero;
                load_ops     = accept_multi;
                load_single  = accept && !accept_multi;
            end
            ITER: begin
                BUSY       = 1'b1;
                step_en    = 1'b1;
                load_multi = (cnt_q == CNT_LAST);
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // One multiply (shift-add) or restoring-divide step
    // ------------------------------------------------------------------
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        // only used when div_ge, so the difference always fits in WIDTH bits
        div_diff  = div_shift[WIDTH-1:0] - opb_q;
        if (op_q == OP_MUL) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else begin
            step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], div_ge};
        end
    end

    // the last step is captured straight from the step logic, so the result
    // registers load on the same edge as the final iteration
    always_comb begin
        mc_res = step_hi;
        mc_c   = 1'b0;
        case (op_q)
            OP_MUL: begin
                mc_res = step_lo;
                mc_c   = |step_hi;
            end
            OP_DIVU: mc_res = step_lo;
            default: mc_res = step_hi;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op_q  <= OP_NON;
            opb_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            cnt_q <= '0;
        end else if (load_ops) begin
            op_q  <= S_ALU;
            opb_q <= DATA_B;
            hi_q  <= '0;
            lo_q  <= DATA_A;
            cnt_q <= '0;
        end else if (step_en) begin
            hi_q  <= step_hi;
            lo_q  <= step_lo;
            cnt_q <= cnt_q + SHW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Single-cycle operations (including divide by zero)
    // ------------------------------------------------------------------
    always_comb begin
        sh       = DATA_B[SHW-1:0];
        add_sum  = {1'b0, DATA_A} + {1'b0, DATA_B};
        sub_diff = {1'b0, DATA_A} - {1'b0, DATA_B};
        // bit WIDTH of the widened left shift is A[WIDTH-sh], and 0 when sh=0
        shl_ext  = {{WIDTH{1'b0}}, DATA_A} << sh;
        sc_res   = '0;
        sc_c     = 1'b0;
        sc_v     = 1'b0;
        case (S_ALU)
            OP_ADD: begin
                sc_res = add_sum[WIDTH-1:0];
                sc_c   = add_sum[WIDTH];
                sc_v   = (DATA_A[WIDTH-1] == DATA_B[WIDTH-1]) &&
                         (add_sum[WIDTH-1] != DATA_A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = sub_diff[WIDTH-1:0];
                sc_c   = sub_diff[WIDTH];
                sc_v   = (DATA_A[WIDTH-1] != DATA_B[WIDTH-1]) &&
                         (sub_diff[WIDTH-1] != DATA_A[WIDTH-1]);
            end
            OP_AND: sc_res = DATA_A & DATA_B;
            OP_OR:  sc_res = DATA_A | DATA_B;
            OP_XOR: sc_res = DATA_A ^ DATA_B;
            OP_DIVU: begin
                sc_res = '1;
                sc_v   = 1'b1;
            end
            OP_REMU: begin
                sc_res = DATA_A;
                sc_v   = 1'b1;
            end
            OP_SLL: begin
                sc_res = shl_ext[WIDTH-1:0];
                sc_c   = shl_ext[WIDTH];
            end
            OP_ROL: begin
                sc_res = shl_ext[WIDTH-1:0] | shl_ext[2*WIDTH-1:WIDTH];
                sc_c   = shl_ext[WIDTH];
            end
            OP_SRL: begin
                sc_res = DATA_A >> sh;
                sc_c   = (sh == '0) ? 1'b0 : DATA_A[sh - SHW'(1)];
            end
            OP_SRA: begin
                sc_res = WIDTH'($signed(DATA_A) >>> sh);
                sc_c   = (sh == '0) ? 1'b0 : DATA_A[sh - SHW'(1)];
            end
            OP_IDT: sc_res = DATA_B;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Result registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            done_q <= 1'b0;
            out_q  <= '0;
            flag_q <= '0;
        end else if (load_single) begin
            done_q <= 1'b1;
            out_q  <= sc_res;
            flag_q <= make_flags(sc_res, sc_c, sc_v);
        end else if (load_multi) begin
            done_q <= 1'b1;
            out_q  <= mc_res;
            flag_q <= make_flags(mc_res, mc_c, 1'b0);
        end else begin
            done_q <= 1'b0;
        end
    end

    assign DONE     = done_q;
    assign ALU_OUT  = out_q;
    assign FLAG_OUT = flag_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// -----------------------------------------------------------------------------
// tb_alu_multicycle
//   Self-checking bench for alu_multicycle at WIDTH=16. Expected results are
//   pushed to a scoreboard queue when an operation is issued and popped when
//   DONE is seen. Inputs change on the falling edge; outputs are sampled on
//   the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  s_alu;
    logic [15:0] data_a;
    logic [15:0] data_b;
    logic        busy;
    logic        done;
    logic [15:0] alu_out;
    logic [3:0]  flag_out;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] out;
        logic [3:0]  flags;
        int          lat;
    } exp_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] eo;
        logic [3:0]  ef;
    } vec_t;

    exp_t sb[$];

    alu_multicycle #(.WIDTH(16)) dut (
        .CLK      (clk),
        .RST      (rst),
        .START    (start),
        .S_ALU    (s_alu),
        .DATA_A   (data_a),
        .DATA_B   (data_b),
        .BUSY     (busy),
        .DONE     (done),
        .ALU_OUT  (alu_out),
        .FLAG_OUT (flag_out)
    );

    always #5 clk = ~clk;

    // reference model: {result, S, Z, C, V}
    function automatic logic [19:0] model(input logic [3:0] op,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
        logic [15:0] r;
        logic [16:0] s17;
        logic [31:0] p;
        logic [3:0]  sh;
        logic        c;
        logic        v;
        r  = 16'h0;
        c  = 1'b0;
        v  = 1'b0;
        sh = b[3:0];
        case (op)
            4'h0: begin
                s17 = {1'b0, a} + {1'b0, b};
                r = s17[15:0];
                c = s17[16];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            4'h1: begin
                r = a - b;
                c = (a < b);
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            4'h5: begin
                p = {16'h0, a} * {16'h0, b};
                r = p[15:0];
                c = (p[31:16] != 16'h0);
            end
            4'h6: begin
                if (b == 16'h0) begin r = 16'hFFFF; v = 1'b1; end
                else r = a / b;
            end
            4'h7: begin
                if (b == 16'h0) begin r = a; v = 1'b1; end
                else r = a % b;
            end
            4'h8: begin
                r = a << sh;
                c = (sh != 0) ? a[16 - sh] : 1'b0;
            end
            4'h9: begin
                r = (sh != 0) ? ((a << sh) | (a >> (16 - sh))) : a;
                c = (sh != 0) ? a[16 - sh] : 1'b0;
            end
            4'hA: begin
                r = a >> sh;
                c = (sh != 0) ? a[sh - 1] : 1'b0;
            end
            4'hB: begin
                r = $signed(a) >>> sh;
                c = (sh != 0) ? a[sh - 1] : 1'b0;
            end
            4'hC: r = b;
            default: r = 16'h0;
        endcase
        return {r, r[15], (r == 16'h0), c, v};
    endfunction

    function automatic int exp_lat(input logic [3:0] op, input logic [15:0] b);
        if (op == 4'h5) return 17;
        if ((op == 4'h6 || op == 4'h7) && b != 16'h0) return 17;
        return 1;
    endfunction

    // Issues one op (caller is just past a falling edge), pushes the expected
    // result and waits, bounded, for DONE. lat = falling edges until DONE.
    task automatic drive_op(input logic [3:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] eo,
                            input logic [3:0] ef, output int lat, output int bc);
        exp_t e;
        e.out   = eo;
        e.flags = ef;
        e.lat   = exp_lat(op, b);
        sb.push_back(e);
        s_alu  = op;
        data_a = a;
        data_b = b;
        start  = 1'b1;
        lat    = -1;
        bc     = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (busy) bc++;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start  = 1'b0;
        s_alu  = 4'h0;
        data_a = 16'h0;
        data_b = 16'h0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (alu_out !== 16'h0) begin errors++; $display("FAIL reset_out got=%h exp=0000", alu_out); end
        checks++; if (flag_out !== 4'h0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", flag_out); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_vectors(input string name, input vec_t vt[$]);
        vec_t v;
        exp_t e;
        int   lat;
        int   bc;
        for (int k = 0; k < vt.size(); k++) begin
            v = vt[k];
            drive_op(v.op, v.a, v.b, v.eo, v.ef, lat, bc);
            e = sb.pop_front();
            checks++;
            if (lat !== e.lat) begin
                errors++;
                $display("FAIL %s_latency[%0d] op=%h a=%h b=%h got=%0d exp=%0d", name, k, v.op, v.a, v.b, lat, e.lat);
            end
            checks++;
            if (bc !== e.lat - 1) begin
                errors++;
                $display("FAIL %s_busy_cycles[%0d] op=%h got=%0d exp=%0d", name, k, v.op, bc, e.lat - 1);
            end
            checks++;
            if (alu_out !== e.out) begin
                errors++;
                $display("FAIL %s_out[%0d] op=%h a=%h b=%h got=%h exp=%h", name, k, v.op, v.a, v.b, alu_out, e.out);
            end
            checks++;
            if (flag_out !== e.flags) begin
                errors++;
                $display("FAIL %s_flags[%0d] op=%h a=%h b=%h got=%b exp=%b", name, k, v.op, v.a, v.b, flag_out, e.flags);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL %s_done_width[%0d] got=%b exp=0", name, k, done);
            end
        end
    endtask

    task automatic test_directed();
        vec_t vt[$];
        vt.push_back('{4'h0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001});  // ADD overflow
        vt.push_back('{4'h1, 16'h0000, 16'h0001, 16'hFFFF, 4'b1010});  // SUB borrow
        vt.push_back('{4'hB, 16'h8001, 16'h0001, 16'hC000, 4'b1010});  // SRA
        vt.push_back('{4'h9, 16'h8001, 16'h0004, 16'h0018, 4'b0000});  // ROL
        vt.push_back('{4'h8, 16'h8000, 16'h0001, 16'h0000, 4'b0110});  // SLL
        vt.push_back('{4'hA, 16'h0003, 16'h0002, 16'h0000, 4'b0110});  // SRL
        vt.push_back('{4'h8, 16'h1234, 16'h0000, 16'h1234, 4'b0000});  // sh=0
        vt.push_back('{4'h2, 16'hF0F0, 16'hFF00, 16'hF000, 4'b1000});  // AND
        vt.push_back('{4'hC, 16'h0000, 16'hABCD, 16'hABCD, 4'b1000});  // IDT
        vt.push_back('{4'hF, 16'h0005, 16'h0006, 16'h0000, 4'b0100});  // NON
        vt.push_back('{4'hD, 16'h0005, 16'h0006, 16'h0000, 4'b0100});  // unused code
        vt.push_back('{4'h6, 16'h1234, 16'h0000, 16'hFFFF, 4'b1001});  // DIVU by 0
        vt.push_back('{4'h7, 16'h1234, 16'h0000, 16'h1234, 4'b0001});  // REMU by 0
        vt.push_back('{4'h5, 16'h0123, 16'h0100, 16'h2300, 4'b0010});  // MUL high set
        vt.push_back('{4'h5, 16'h00FF, 16'h00FF, 16'hFE01, 4'b1000});  // MUL
        vt.push_back('{4'h5, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0010});  // MUL max
        vt.push_back('{4'h6, 16'd1000, 16'd7,    16'h008E, 4'b0000});  // DIVU
        vt.push_back('{4'h7, 16'd1000, 16'd7,    16'h0006, 4'b0000});  // REMU
        vt.push_back('{4'h6, 16'hFFFF, 16'h0001, 16'hFFFF, 4'b1000});  // DIVU by 1
        vt.push_back('{4'h7, 16'h0005, 16'h0009, 16'h0005, 4'b0000});  // REMU a<b
        run_vectors("directed", vt);
    endtask

    task automatic test_random();
        vec_t        vt[$];
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [19:0] m;
        for (int k = 0; k < 24; k++) begin
            op = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            b  = 16'($urandom);
            if ((op == 4'h6 || op == 4'h7) && $urandom_range(0, 3) == 0) b = 16'h0;
            if (op >= 4'h6 && op <= 4'h7 && b != 0 && $urandom_range(0, 1) == 1) b = b & 16'h00FF;
            m = model(op, a, b);
            vt.push_back('{op, a, b, m[19:4], m[3:0]});
        end
        run_vectors("random", vt);
    endtask

    task automatic test_busy_ignore();
        exp_t        e;
        int          ndone;
        int          first;
        logic [15:0] got;
        e.out = 16'hFE01; e.flags = 4'b1000; e.lat = 17;
        sb.push_back(e);
        s_alu = 4'h5; data_a = 16'h00FF; data_b = 16'h00FF; start = 1'b1;
        ndone = 0; first = -1; got = 16'h0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 3) begin
                s_alu = 4'h0; data_a = 16'h0001; data_b = 16'h0001; start = 1'b1;
            end
            if (i == 4) start = 1'b0;
            if (done) begin
                ndone++;
                if (first < 0) begin first = i; got = alu_out; end
            end
        end
        e = sb.pop_front();
        checks++; if (ndone !== 1) begin errors++; $display("FAIL busy_ignore_done_count got=%0d exp=1", ndone); end
        checks++; if (first !== e.lat) begin errors++; $display("FAIL busy_ignore_latency got=%0d exp=%0d", first, e.lat); end
        checks++; if (got !== e.out) begin errors++; $display("FAIL busy_ignore_out got=%h exp=%h", got, e.out); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat1;
        int   lat2;
        e.out = 16'h2300; e.flags = 4'b0010; e.lat = 17; sb.push_back(e);
        e.out = 16'h008E; e.flags = 4'b0000; e.lat = 17; sb.push_back(e);
        s_alu = 4'h5; data_a = 16'h0123; data_b = 16'h0100; start = 1'b1;
        lat1 = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (done) begin lat1 = i; break; end
        end
        e = sb.pop_front();
        checks++; if (lat1 !== e.lat) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=%0d", lat1, e.lat); end
        checks++; if (alu_out !== e.out) begin errors++; $display("FAIL b2b_first_out got=%h exp=%h", alu_out, e.out); end
        // new request issued in the DONE cycle
        s_alu = 4'h6; data_a = 16'd1000; data_b = 16'd7; start = 1'b1;
        lat2 = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (done) begin lat2 = i; break; end
        end
        e = sb.pop_front();
        checks++; if (lat2 !== e.lat) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat2, e.lat); end
        checks++; if (alu_out !== e.out) begin errors++; $display("FAIL b2b_second_out got=%h exp=%h", alu_out, e.out); end
        // streaming single-cycle ops: START held for three consecutive cycles
        e.out = 16'h0003; e.flags = 4'b0000; e.lat = 1; sb.push_back(e);
        e.out = 16'h0002; e.flags = 4'b0000; e.lat = 1; sb.push_back(e);
        e.out = 16'hFF00; e.flags = 4'b1000; e.lat = 1; sb.push_back(e);
        s_alu = 4'h0; data_a = 16'h0001; data_b = 16'h0002; start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin s_alu = 4'h1; data_a = 16'h0005; data_b = 16'h0003; end
            if (k == 1) begin s_alu = 4'h4; data_a = 16'hF0F0; data_b = 16'h0FF0; end
            if (k == 2) start = 1'b0;
            e = sb.pop_front();
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL stream_done[%0d] got=%b exp=1", k, done); end
            checks++; if (alu_out !== e.out) begin errors++; $display("FAIL stream_out[%0d] got=%h exp=%h", k, alu_out, e.out); end
            checks++; if (flag_out !== e.flags) begin errors++; $display("FAIL stream_flags[%0d] got=%b exp=%b", k, flag_out, e.flags); end
        end
        // results hold while idle
        repeat (5) @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL hold_done got=%b exp=0", done); end
        checks++; if (alu_out !== 16'hFF00) begin errors++; $display("FAIL hold_out got=%h exp=ff00", alu_out); end
        checks++; if (flag_out !== 4'b1000) begin errors++; $display("FAIL hold_flags got=%b exp=1000", flag_out); end
    endtask

    task automatic test_reset_mid_mul();
        exp_t e;
        int   lat;
        int   bc;
        int   ndone;
        drive_op(4'h0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, lat, bc);
        e = sb.pop_front();
        checks++; if (alu_out !== e.out) begin errors++; $display("FAIL pre_reset_out got=%h exp=%h", alu_out, e.out); end
        @(negedge clk);
        s_alu = 4'h5; data_a = 16'h0123; data_b = 16'h0100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_mul_busy got=%b exp=1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy got=%b exp=0", busy); end
        checks++; if (alu_out !== 16'h0) begin errors++; $display("FAIL async_reset_out got=%h exp=0000", alu_out); end
        checks++; if (flag_out !== 4'h0) begin errors++; $display("FAIL async_reset_flags got=%b exp=0000", flag_out); end
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL aborted_done got=%0d exp=0", ndone); end
        // ALU usable again after the abort
        drive_op(4'h0, 16'h0001, 16'h0001, 16'h0002, 4'b0000, lat, bc);
        e = sb.pop_front();
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL post_reset_latency got=%0d exp=%0d", lat, e.lat); end
        checks++; if (alu_out !== e.out) begin errors++; $display("FAIL post_reset_out got=%h exp=%h", alu_out, e.out); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
